// File: rtl/line_draw_sequencer.sv
// line_draw_sequencer: arbitrates two line requesters onto a Bresenham drawer, forwards drawn pixels
// as framebuffer writes, performs full-screen clear sweeps and aborts stuck draws via a watchdog.
module line_draw_sequencer #(
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480,
   parameter int MAX_CYCLES = 4096
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [1:0][10:0] req_x0,
   input  logic [1:0][10:0] req_y0,
   input  logic [1:0][10:0] req_x1,
   input  logic [1:0][10:0] req_y1,
   input  logic [1:0]      req_color,
   input  logic            clear_req,
   output logic            ld_reset,
   output logic [10:0]     ld_x0,
   output logic [10:0]     ld_y0,
   output logic [10:0]     ld_x1,
   output logic [10:0]     ld_y1,
   input  logic [10:0]     ld_x,
   input  logic [10:0]     ld_y,
   input  logic            ld_done,
   output logic [10:0]     pix_x,
   output logic [10:0]     pix_y,
   output logic            pix_color,
   output logic            pix_we,
   output logic            busy,
   output logic            line_done,
   output logic            clear_done,
   output logic            err_timeout
);
   localparam int WW = $clog2(MAX_CYCLES + 1);
   localparam logic [10:0] XLIM  = 11'(SCREEN_W);
   localparam logic [10:0] YLIM  = 11'(SCREEN_H);
   localparam logic [10:0] XLAST = 11'(SCREEN_W - 1);
   localparam logic [10:0] YLAST = 11'(SCREEN_H - 1);
   localparam logic [WW-1:0] WD_LAST = WW'(MAX_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, DRAW, CLEAR} state_t;

   state_t        state, state_nx;
   logic          pending, pref, color, grant, accept, clipped, timeout, clear_last;
   logic [WW-1:0] wd;
   logic [10:0]   cx, cy;

   // pref names the requester that wins when both are valid; it flips to the loser after each grant
   always_comb begin
      grant      = (&req_valid) ? pref : req_valid[1];
      accept     = (state == IDLE) && !pending && (|req_valid);
      req_ready  = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
      clipped    = (ld_x >= XLIM) || (ld_y >= YLIM);
      timeout    = (state == DRAW) && !ld_done && (wd == WD_LAST);
      clear_last = (cx == XLAST) && (cy == YLAST);
      pix_x      = (state == DRAW) ? ld_x : (state == CLEAR) ? cx : 11'd0;
      pix_y      = (state == DRAW) ? ld_y : (state == CLEAR) ? cy : 11'd0;
      pix_color  = (state == DRAW) && color;
      pix_we     = ((state == DRAW) && !clipped && !timeout) || (state == CLEAR);
      busy       = state != IDLE;
      state_nx   = state;
      case (state)
         IDLE:    state_nx = pending ? CLEAR : accept ? LOAD : IDLE;
         LOAD:    state_nx = DRAW;
         DRAW:    state_nx = (ld_done || timeout) ? IDLE : DRAW;
         default: state_nx = clear_last ? IDLE : CLEAR;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pending     <= 1'b0;
         pref        <= 1'b0;
         color       <= 1'b0;
         ld_reset    <= 1'b0;
         ld_x0       <= '0;
         ld_y0       <= '0;
         ld_x1       <= '0;
         ld_y1       <= '0;
         wd          <= '0;
         cx          <= '0;
         cy          <= '0;
         line_done   <= 1'b0;
         clear_done  <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_nx;
         // IDLE with a pending clear always moves to CLEAR, so leaving IDLE consumes the request
         pending     <= clear_req || (pending && state != IDLE);
         ld_reset    <= accept;
         if (accept) begin
            ld_x0 <= req_x0[grant];
            ld_y0 <= req_y0[grant];
            ld_x1 <= req_x1[grant];
            ld_y1 <= req_y1[grant];
            color <= req_color[grant];
            pref  <= !grant;
         end
         wd          <= (state == DRAW) ? wd + 1'b1 : '0;
         if (state != CLEAR) begin
            cx <= '0;
            cy <= '0;
         end else if (cx == XLAST) begin
            cx <= '0;
            cy <= cy + 11'd1;
         end else begin
            cx <= cx + 11'd1;
         end
         line_done   <= (state == DRAW) && ld_done;
         clear_done  <= (state == CLEAR) && clear_last;
         err_timeout <= timeout;
      end
   end
endmodule

// File: tb/tb_line_draw_sequencer.sv
// tb_line_draw_sequencer: table-driven line vectors plus hand sequences for clear, watchdog and reset,
// against a behavioural drawer stub that steps x from x0 to x1.
module tb_line_draw_sequencer;
   localparam int W = 8, H = 4, MC = 16;

   logic             clk = 1'b0, reset = 1'b1;
   logic [1:0]       req_valid = '0, req_ready, req_color = '0;
   logic [1:0][10:0] req_x0 = '0, req_y0 = '0, req_x1 = '0, req_y1 = '0;
   logic             clear_req = 1'b0, ld_reset, ld_done, pix_color, pix_we, busy;
   logic             line_done, clear_done, err_timeout;
   logic [10:0]      ld_x0, ld_y0, ld_x1, ld_y1, ld_x, ld_y, pix_x, pix_y;

   always #5 clk = ~clk;

   line_draw_sequencer #(.SCREEN_W(W), .SCREEN_H(H), .MAX_CYCLES(MC)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1), .req_color(req_color),
      .clear_req(clear_req), .ld_reset(ld_reset), .ld_x0(ld_x0), .ld_y0(ld_y0), .ld_x1(ld_x1),
      .ld_y1(ld_y1), .ld_x(ld_x), .ld_y(ld_y), .ld_done(ld_done), .pix_x(pix_x), .pix_y(pix_y),
      .pix_color(pix_color), .pix_we(pix_we), .busy(busy), .line_done(line_done),
      .clear_done(clear_done), .err_timeout(err_timeout)
   );

   // drawer stub; hang freezes it so done never comes
   logic [10:0] sx;
   logic        sact, hang = 1'b0;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         sx <= '0; sact <= 1'b0;
      end else if (ld_reset) begin
         sx <= ld_x0; sact <= 1'b1;
      end else if (sact && !hang) begin
         if (sx == ld_x1) sact <= 1'b0;
         else sx <= sx + 11'd1;
      end
   end
   assign ld_x = sx;
   assign ld_y = ld_y0;
   assign ld_done = sact && !hang && (sx == ld_x1);

   logic [10:0] wx[512], wy[512];
   logic        wc[512];
   int nw = 0, n_rdy = 0, n_ldr = 0, n_ld = 0, n_cd = 0, n_to = 0, n_busy = 0;
   always @(negedge clk) begin
      if (pix_we && nw < 512) begin
         wx[nw] = pix_x; wy[nw] = pix_y; wc[nw] = pix_color; nw++;
      end
      if (req_ready != 0) n_rdy++;
      if (ld_reset) n_ldr++;
      if (line_done) n_ld++;
      if (clear_done) n_cd++;
      if (err_timeout) n_to++;
      if (busy) n_busy++;
   end

   int errors = 0, checks = 0;
   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  mask;
      logic [10:0] x0, y0, x1;
      logic        color, grant;
      int          writes;
      logic [10:0] fx;
   } vec_t;
   vec_t vt[8];

   task automatic set_cmd(input logic [10:0] x0, input logic [10:0] y0, input logic [10:0] x1,
                          input logic c);
      req_x0 = {x0, x0}; req_y0 = {y0, y0}; req_x1 = {x1, x1}; req_y1 = {y0, y0};
      req_color = {~c, c};
   endtask

   task automatic run_line(input vec_t v, input string tag);
      int  b_nw, b_rdy, b_ldr, b_ld, b_to;
      bit  got, fin;
      b_nw = nw; b_rdy = n_rdy; b_ldr = n_ldr; b_ld = n_ld; b_to = n_to;
      got = 0; fin = 0;
      @(posedge clk); #1;
      set_cmd(v.x0, v.y0, v.x1, v.color);
      req_valid = v.mask;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk); #1;
         if (req_ready != 0) begin
            got = 1;
            chk({tag, " grant"}, int'(req_ready), v.grant ? 2 : 1);
            @(posedge clk); #1 req_valid = '0;
         end
      end
      chk({tag, " accepted"}, int'(got), 1);
      for (int i = 0; i < 40 && !fin; i++) begin
         @(negedge clk); #1;
         fin = line_done || err_timeout;
      end
      chk({tag, " line_done_seen"}, int'(line_done), 1);
      chk({tag, " busy_after"}, int'(busy), 0);
      chk({tag, " ready_pulses"}, n_rdy - b_rdy, 1);
      chk({tag, " ld_reset_cycles"}, n_ldr - b_ldr, 1);
      chk({tag, " line_done_pulses"}, n_ld - b_ld, 1);
      chk({tag, " timeouts"}, n_to - b_to, 0);
      chk({tag, " writes"}, nw - b_nw, v.writes);
      for (int k = 0; k < v.writes && k < nw - b_nw; k++) begin
         chk({tag, " pix_x"}, int'(wx[b_nw + k]), int'(v.fx) + k);
         chk({tag, " pix_y"}, int'(wy[b_nw + k]), int'(v.y0));
         chk({tag, " pix_color"}, int'(wc[b_nw + k]), int'(v.color ^ v.grant));
      end
   endtask

   initial begin
      int  b_nw, b_cd, b_to, b_ld, b_busy, b2;
      bit  fin, early;
      vec_t vf;
      // mask, x0, y0, x1, colour(req0), expected grant, expected writes, first written x
      vt[0] = '{2'b11, 11'd1, 11'd0, 11'd3,  1'b1, 1'b0, 3, 11'd1};
      vt[1] = '{2'b11, 11'd4, 11'd1, 11'd6,  1'b1, 1'b1, 3, 11'd4};
      vt[2] = '{2'b11, 11'd0, 11'd2, 11'd0,  1'b0, 1'b0, 1, 11'd0};
      vt[3] = '{2'b01, 11'd2, 11'd1, 11'd5,  1'b1, 1'b0, 4, 11'd2};
      vt[4] = '{2'b10, 11'd0, 11'd3, 11'd2,  1'b1, 1'b1, 3, 11'd0};
      vt[5] = '{2'b01, 11'd5, 11'd2, 11'd10, 1'b1, 1'b0, 3, 11'd5};
      vt[6] = '{2'b10, 11'd1, 11'd4, 11'd3,  1'b1, 1'b1, 0, 11'd0};
      vt[7] = '{2'b01, 11'd7, 11'd3, 11'd7,  1'b1, 1'b0, 1, 11'd7};

      repeat (2) @(negedge clk);
      #1;
      chk("reset busy", int'(busy), 0);
      chk("reset pix_we", int'(pix_we), 0);
      chk("reset ld_reset", int'(ld_reset), 0);
      chk("reset line_done", int'(line_done), 0);
      chk("reset ld_x1", int'(ld_x1), 0);
      @(posedge clk); #1 reset = 1'b0;

      for (int i = 0; i < 8; i++) run_line(vt[i], $sformatf("vec%0d", i));

      // clear sweep with a line request queued behind it
      b_nw = nw; b_cd = n_cd; early = 0; fin = 0;
      @(posedge clk); #1 clear_req = 1'b1;
      set_cmd(11'd0, 11'd2, 11'd1, 1'b1);
      @(posedge clk); #1 clear_req = 1'b0; req_valid = 2'b01;
      #1 chk("clr ready_while_pending", int'(req_ready), 0);
      for (int i = 0; i < 60 && !fin; i++) begin
         @(negedge clk); #1;
         if (clear_done) fin = 1;
         else if (req_ready != 0) early = 1;
      end
      chk("clr done_seen", int'(fin), 1);
      chk("clr ready_during_clear", int'(early), 0);
      chk("clr writes", nw - b_nw, W * H);
      chk("clr done_pulses", n_cd - b_cd, 1);
      for (int k = 0; k < W * H && b_nw + k < 512; k++) begin
         chk("clr pix_x", int'(wx[b_nw + k]), k % W);
         chk("clr pix_y", int'(wy[b_nw + k]), k / W);
         chk("clr pix_color", int'(wc[b_nw + k]), 0);
      end
      chk("clr ready_after", int'(req_ready), 1);
      @(posedge clk); #1 req_valid = '0;
      b2 = nw; fin = 0;
      for (int i = 0; i < 20 && !fin; i++) begin
         @(negedge clk); #1;
         fin = line_done;
      end
      chk("clr queued_line_done", int'(fin), 1);
      chk("clr queued_line_writes", nw - b2, 2);

      // second clear_req arriving mid-sweep re-arms a whole new sweep
      b_nw = nw; b_cd = n_cd;
      @(posedge clk); #1 clear_req = 1'b1;
      @(posedge clk); #1 clear_req = 1'b0;
      repeat (10) @(posedge clk);
      #1 clear_req = 1'b1;
      @(posedge clk); #1 clear_req = 1'b0;
      for (int i = 0; i < 120 && n_cd - b_cd < 2; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      #1;
      chk("rearm done_pulses", n_cd - b_cd, 2);
      chk("rearm writes", nw - b_nw, 2 * W * H);
      chk("rearm busy_after", int'(busy), 0);

      // watchdog abort
      hang = 1'b1;
      b_nw = nw; b_to = n_to; b_ld = n_ld; b_busy = n_busy; fin = 0;
      @(posedge clk); #1;
      set_cmd(11'd1, 11'd0, 11'd5, 1'b1);
      req_valid = 2'b01;
      @(negedge clk); #1 chk("wd ready", int'(req_ready), 1);
      @(posedge clk); #1 req_valid = '0;
      for (int i = 0; i < 40 && !fin; i++) begin
         @(negedge clk); #1;
         fin = err_timeout;
      end
      chk("wd err_seen", int'(fin), 1);
      chk("wd err_pulses", n_to - b_to, 1);
      chk("wd line_done_pulses", n_ld - b_ld, 0);
      chk("wd writes", nw - b_nw, MC - 1);
      chk("wd busy_cycles", n_busy - b_busy, MC + 1);
      chk("wd busy_after", int'(busy), 0);
      hang = 1'b0;

      // reset in the middle of a draw
      b_ld = n_ld;
      @(posedge clk); #1;
      set_cmd(11'd0, 11'd0, 11'd7, 1'b1);
      req_valid = 2'b01;
      @(negedge clk); #1 chk("rst ready", int'(req_ready), 1);
      @(posedge clk); #1 req_valid = '0;
      repeat (2) @(posedge clk);
      #1 chk("rst mid_draw_we", int'(pix_we), 1);
      reset = 1'b1;
      #1;
      chk("rst busy", int'(busy), 0);
      chk("rst pix_we", int'(pix_we), 0);
      chk("rst pix_x", int'(pix_x), 0);
      chk("rst ld_x1", int'(ld_x1), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (12) @(negedge clk);
      #1;
      chk("rst no_line_done", n_ld - b_ld, 0);
      chk("rst idle", int'(busy), 0);
      vf = '{2'b11, 11'd2, 11'd0, 11'd4, 1'b0, 1'b0, 3, 11'd2};
      run_line(vf, "post_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
